phy_tx_ps: RTL and testbench

//   Parallel-to-serial transmitter of the PHY link; the transmit end of the phy_rx serial-to-parallel receiver.

---
 rtl/phy_tx_ps.sv | 63 ++++++
 tb/tb_phy_tx_ps.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/phy_tx_ps.sv
// Parallel-to-serial PHY transmitter: 32-bit words out MSB-first, one bit per clk_32f,
// with comma slots for receiver alignment at start-up and whenever no word is offered.
module phy_tx_ps #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_SLOTS = 2
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out_PS,
  output logic        active_tx
);

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t      r_state;
  logic [15:0] r_sync_cnt;
  logic [4:0]  r_cnt;
  logic [31:0] r_shreg;
  logic        w_boundary;
  logic [31:0] w_slot;

  assign w_boundary = (r_cnt == 5'd31);
  // ready depends only on state and bit position so the link layer never sees a combinational loop
  assign ready_out  = (r_state == ST_RUN) && w_boundary;

  always_comb begin
    w_slot = {4{COMMA}};
    if (r_state == ST_RUN && valid_in) w_slot = data_in;
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_SYNC;
      r_sync_cnt  <= '0;
      r_cnt       <= 5'd31;
      r_shreg     <= '0;
      data_out_PS <= 1'b0;
      active_tx   <= 1'b0;
    end else if (w_boundary) begin
      r_shreg     <= {w_slot[30:0], 1'b0};
      data_out_PS <= w_slot[31];
      r_cnt       <= '0;
      if (r_state == ST_SYNC) begin
        r_sync_cnt <= r_sync_cnt + 16'd1;
        if ((r_sync_cnt + 16'd1) == 16'(SYNC_SLOTS)) begin
          r_state   <= ST_RUN;
          active_tx <= 1'b1;
        end
      end
    end else begin
      data_out_PS <= r_shreg[31];
      r_shreg     <= {r_shreg[30:0], 1'b0};
      r_cnt       <= r_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_phy_tx_ps.sv
// Self-checking bench for phy_tx_ps: slot-level reference model driven by edge count since reset release.
module tb_phy_tx_ps;

  localparam int          SYNC_SLOTS = 2;
  localparam logic [31:0] COMMA4     = 32'hBCBCBCBC;

  logic        clk_32f = 1'b0;
  logic        reset_L = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out, data_out_PS, active_tx;

  int checks = 0;
  int errors = 0;

  // Model state: edges since release, current slot contents, received word assembly
  int          n = 0;
  logic [31:0] cur_slot = '0;
  logic [31:0] rx_word = '0;
  logic        last_acc = 1'b0;
  logic [31:0] wq[$];

  phy_tx_ps #(.COMMA(8'hBC), .SYNC_SLOTS(SYNC_SLOTS)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out_PS(data_out_PS),
    .active_tx  (active_tx)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, n, obs, exp);
    end
  endtask

  // One clock edge: check pre-edge ready, advance model, check post-edge outputs.
  task automatic tick(input logic v, input logic [31:0] d);
    int pos, slot;
    logic exp_rdy;
    valid_in = v;
    data_in  = d;
    exp_rdy  = ((n % 32) == 0) && ((n / 32 + 1) > SYNC_SLOTS);
    #1;
    chk("ready", ready_out, exp_rdy);
    @(posedge clk_32f);
    #1;
    n++;
    pos  = (n - 1) % 32;
    slot = (n - 1) / 32 + 1;
    last_acc = 1'b0;
    if (pos == 0) begin
      last_acc = (slot > SYNC_SLOTS) && v;
      cur_slot = last_acc ? d : COMMA4;
    end
    chk("data_out", data_out_PS, cur_slot[31 - pos]);
    rx_word = {rx_word[30:0], data_out_PS};
    if (pos == 31) chk("word", rx_word, cur_slot);
    chk("active", active_tx, (slot >= SYNC_SLOTS));
  endtask

  // Assert reset between edges, verify async clearing, hold, release just after an edge.
  task automatic do_reset();
    #3;
    reset_L = 1'b0;
    #1;
    chk("rst_data", data_out_PS, 0);
    chk("rst_active", active_tx, 0);
    chk("rst_ready", ready_out, 0);
    #40;
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    n = 0;
    cur_slot = '0;
  endtask

  // Feed wq through the handshake; pct is the chance (0-100) of offering a word in each slot.
  task automatic run_queue(input int pct, input int budget);
    logic v;
    int   t;
    v = 1'b0;
    t = 0;
    while (wq.size() > 0 && t < budget) begin
      if ((n % 32) == 31 || n == 0) v = ($urandom_range(1, 100) <= pct);
      if (v) tick(1'b1, wq[0]);
      else   tick(1'b0, $urandom);
      if (last_acc) void'(wq.pop_front());
      t++;
    end
    chk("drain", wq.size(), 0);
  endtask

  initial begin
    // 1: sync commas then idle commas
    #40;
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    for (int i = 0; i < 96; i++) tick(1'b0, '0);

    // 2: word held valid from release, first accepted at edge 65
    do_reset();
    for (int i = 0; i < 64; i++) tick(1'b1, 32'hAABBCCDD);
    chk("no_early_acc", n, 64);
    tick(1'b1, 32'hAABBCCDD);
    chk("acc_edge65", last_acc, 1);
    for (int i = 0; i < 31; i++) tick(1'b1, 32'hAABBCCDD);

    // 3: back-to-back words, contiguous slots
    wq.push_back(32'h00000001);
    wq.push_back(32'hFFFFFFFF);
    wq.push_back(32'h12345678);
    run_queue(100, 200);
    for (int i = 0; i < 32; i++) tick(1'b0, '0);

    // 4: short valid pulse away from the boundary is ignored
    for (int i = 0; i < 5; i++) tick(1'b0, '0);
    tick(1'b1, 32'hDEADBEEF);
    chk("pulse_no_acc", last_acc, 0);
    while ((n % 32) != 0) tick(1'b0, '0);
    for (int i = 0; i < 32; i++) tick(1'b0, '0);

    // 5: reset mid-word at cnt==13, then sync again before data
    tick(1'b1, 32'hCAFEF00D);
    chk("acc_pre_rst", last_acc, 1);
    for (int i = 0; i < 13; i++) tick(1'b0, '0);
    do_reset();
    for (int i = 0; i < 64; i++) tick(1'b1, 32'h5A5A5A5A);
    chk("resync_len", n, 64);
    for (int i = 0; i < 32; i++) tick(1'b0, '0);

    // 6: random stream with random gaps, including comma-valued data
    for (int i = 0; i < 200; i++) wq.push_back((i == 7) ? COMMA4 : $urandom);
    run_queue(70, 200 * 32 * 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
